// File: rtl/alu_sequencer.sv
// Control FSM that sequences RYin/RZin/register-select strobes for one "op Ra, Rb, Rc" instruction.
// Optional macro ALU_SEQ_STALL_EN adds a stall input that freezes state and all registered outputs.
module alu_sequencer #(
   parameter logic [4:0] MUL_OP = 5'b01110,
   parameter logic [4:0] DIV_OP = 5'b01111
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [3:0]  ra,
   input  logic [3:0]  rb,
   input  logic [3:0]  rc,
   input  logic [4:0]  op_in,
`ifdef ALU_SEQ_STALL_EN
   input  logic        stall,
`endif
   output logic [15:0] Rout,
   output logic [15:0] Rin,
   output logic        RYin,
   output logic        RYout,
   output logic        RZin,
   output logic        RZLOout,
   output logic        RZHIout,
   output logic        HIin,
   output logic        LOin,
   output logic [4:0]  ops,
   output logic        busy,
   output logic        done,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t      r_state, w_next;
   logic [3:0]  r_ra, r_rb, r_rc;
   logic [4:0]  r_op;
   logic        w_capture, w_adv, w_is64;
   logic [3:0]  w_ra, w_rb, w_rc;
   logic [4:0]  w_op;
   logic [15:0] w_rout, w_rin;
   logic        w_ryin, w_ryout, w_rzin, w_rzlo, w_rzhi, w_hiin, w_loin, w_busy, w_done;
   logic [4:0]  w_ops;

`ifdef ALU_SEQ_STALL_EN
   assign w_adv = ~stall;
`else
   assign w_adv = 1'b1;
`endif

   // Operands seen by the output decode: live inputs on the capture edge, latched copy afterwards.
   assign w_capture = (r_state == S_IDLE) && start;
   assign w_ra      = w_capture ? ra    : r_ra;
   assign w_rb      = w_capture ? rb    : r_rb;
   assign w_rc      = w_capture ? rc    : r_rc;
   assign w_op      = w_capture ? op_in : r_op;
   assign w_is64    = (w_op == MUL_OP) || (w_op == DIV_OP);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = start ? S_T0 : S_IDLE;
         S_T0:    w_next = S_T1;
         S_T1:    w_next = S_T2;
         S_T2:    w_next = w_is64 ? S_T3 : S_DONE;
         S_T3:    w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Output decode from the next state so every strobe comes straight off a flop.
   always_comb begin
      w_rout  = 16'h0000;
      w_rin   = 16'h0000;
      w_ryin  = 1'b0;
      w_ryout = 1'b0;
      w_rzin  = 1'b0;
      w_rzlo  = 1'b0;
      w_rzhi  = 1'b0;
      w_hiin  = 1'b0;
      w_loin  = 1'b0;
      w_done  = 1'b0;
      w_busy  = (w_next != S_IDLE);
      w_ops   = (w_next != S_IDLE) ? w_op : 5'b00000;
      case (w_next)
         S_T0: begin
            w_rout = 16'h0001 << w_rb;
            w_ryin = 1'b1;
         end
         S_T1: begin
            w_rout  = 16'h0001 << w_rc;
            w_ryout = 1'b1;
            w_rzin  = 1'b1;
         end
         S_T2: begin
            w_rzlo = 1'b1;
            if (w_is64) w_loin = 1'b1;
            else        w_rin  = 16'h0001 << w_ra;
         end
         S_T3: begin
            w_rzhi = 1'b1;
            w_hiin = 1'b1;
         end
         S_DONE:  w_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         r_state <= S_IDLE;
         r_ra    <= 4'd0;
         r_rb    <= 4'd0;
         r_rc    <= 4'd0;
         r_op    <= 5'd0;
         Rout    <= 16'h0000;
         Rin     <= 16'h0000;
         RYin    <= 1'b0;
         RYout   <= 1'b0;
         RZin    <= 1'b0;
         RZLOout <= 1'b0;
         RZHIout <= 1'b0;
         HIin    <= 1'b0;
         LOin    <= 1'b0;
         ops     <= 5'b00000;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else if (w_adv) begin
         r_state <= w_next;
         r_ra    <= w_ra;
         r_rb    <= w_rb;
         r_rc    <= w_rc;
         r_op    <= w_op;
         Rout    <= w_rout;
         Rin     <= w_rin;
         RYin    <= w_ryin;
         RYout   <= w_ryout;
         RZin    <= w_rzin;
         RZLOout <= w_rzlo;
         RZHIout <= w_rzhi;
         HIin    <= w_hiin;
         LOin    <= w_loin;
         ops     <= w_ops;
         busy    <= w_busy;
         done    <= w_done;
      end
   end

   assign dbg_state = r_state;

endmodule
